// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  // Transmitter FSM states; StParity is only visited when parity is enabled.
  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Serial line levels.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts r_clk cycles within one serial bit and flags the last one.
module baud_tick_gen #(
  parameter int unsigned clks_per_bit = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  output logic                            bit_end,
  output logic [$clog2(clks_per_bit)-1:0] count
);

  localparam int unsigned CntW = $clog2(clks_per_bit);
  localparam logic [CntW-1:0] LastCnt = CntW'(clks_per_bit - 1);

  logic [CntW-1:0] count_q, count_d;

  assign bit_end = (count_q == LastCnt);
  assign count   = count_q;

  // Restart on clear (state entry) and wrap at the end of each bit.
  always_comb begin
    count_d = count_q + CntW'(1);
    if (clear || bit_end) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO read port and serialises each one as
// start | data LSB first | optional even parity | stop.
module fifo_uart_tx #(
  parameter int unsigned word_width   = 8,
  parameter int unsigned clks_per_bit = 16,
  parameter bit          parity_en    = 1'b0
) (
  input  logic                  r_clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  empty,
  input  logic [word_width-1:0] fifo_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  import fifo_uart_pkg::*;

  localparam int unsigned BitCntW = $clog2(word_width + 1);
  localparam int unsigned BaudW   = $clog2(clks_per_bit);
  localparam logic [BitCntW-1:0] LastBit    = BitCntW'(word_width - 1);
  localparam logic [BaudW-1:0]   PreLastCnt = BaudW'(clks_per_bit - 2);

  state_e                state_q, state_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  baud_clear;
  logic [BaudW-1:0]      baud_cnt;

  // Counter restarts on every state entry and is held at zero while idle.
  assign baud_clear = (state_d != state_q) || (state_q == StIdle);

  baud_tick_gen #(
    .clks_per_bit(clks_per_bit)
  ) u_baud (
    .clk    (r_clk),
    .reset_n(reset_n),
    .clear  (baud_clear),
    .bit_end(bit_end),
    .count  (baud_cnt)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;

    unique case (state_q)
      StIdle:  if (en && !empty) state_d = StPop;
      StPop:   state_d = StLoad;
      StLoad: begin
        // The popped word is valid on fifo_data during this cycle.
        shift_d   = fifo_data;
        parity_d  = ^fifo_data;
        bit_cnt_d = '0;
        state_d   = StStart;
      end
      StStart: if (bit_end) state_d = StData;
      StData: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (bit_cnt_q == LastBit) state_d = parity_en ? StParity : StStop;
        end
      end
      StParity: if (bit_end) state_d = StStop;
      StStop:   if (bit_end) state_d = (en && !empty) ? StPop : StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are decoded from the upcoming state so they can be registered.
    rd_d   = (state_d == StPop);
    busy_d = (state_d != StIdle);
    // Next cycle is the final stop-bit cycle.
    done_d = (state_q == StStop) && (baud_cnt == PreLastCnt);

    unique case (state_d)
      StStart:  tx_d = LINE_START;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = LINE_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= LINE_IDLE;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign rd      = rd_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: lane 0 runs without parity, lane 1 with even parity.
module tb_fifo_uart_tx;

  localparam int unsigned Cps = 4;
  localparam int unsigned Ww  = 8;

  logic r_clk   = 1'b0;
  logic reset_n = 1'b0;
  logic en      = 1'b0;

  int cyc        = 0;
  int vectors    = 0;
  int miscompares = 0;

  // FIFO storage and expected-word queues, written only by the stimulus process.
  logic [7:0] mem     [2][16];
  int         wptr    [2] = '{0, 0};
  logic [7:0] exp_mem [2][32];
  int         exp_wr  [2] = '{0, 0};

  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    logic       tx, rd, busy, tx_done, empty;
    logic [7:0] fdata = '0;
    int         rptr = 0;
    int         rd_cnt = 0, underflow = 0, frames = 0, exp_rd = 0, last_end = -1000;
    int         gap_q[$];
    logic [7:0] last_rx = '0;
    logic       last_par = 1'b0;

    assign empty = (wptr[g] == rptr);

    fifo_uart_tx #(
      .word_width  (Ww),
      .clks_per_bit(Cps),
      .parity_en   (g == 1)
    ) dut (
      .r_clk    (r_clk),
      .reset_n  (reset_n),
      .en       (en),
      .empty    (empty),
      .fifo_data(fdata),
      .rd       (rd),
      .tx       (tx),
      .busy     (busy),
      .tx_done  (tx_done)
    );

    // FIFO read port: popped word appears in the cycle after the rd edge.
    always @(posedge r_clk) begin
      if (rd) begin
        if (empty) begin
          underflow <= underflow + 1;
        end else begin
          fdata  <= mem[g][rptr % 16];
          rptr   <= rptr + 1;
          rd_cnt <= rd_cnt + 1;
        end
      end
    end

    // Monitor: on each start bit, pop the expected word and check the frame cycle by cycle.
    initial begin : mon
      logic       prev, expbit, par, aborted;
      logic [7:0] w, rx;
      int         nb, werr, derr, berr, bi;
      prev = 1'b1;
      forever begin
        @(negedge r_clk);
        if (reset_n && prev && !tx) begin
          if (exp_rd >= exp_wr[g]) begin
            chk($sformatf("lane%0d_spurious_frame", g), 1, 0);
            w = '0;
          end else begin
            w = exp_mem[g][exp_rd];
          end
          exp_rd++;
          gap_q.push_back(cyc - last_end - 1);
          nb = 10 + g;
          werr = 0; derr = 0; berr = 0; aborted = 1'b0; rx = '0; par = 1'b0;
          for (int k = 0; k < nb * int'(Cps); k++) begin
            if (k > 0) @(negedge r_clk);
            if (!reset_n) begin
              aborted = 1'b1;
              break;
            end
            bi = k / int'(Cps);
            if (bi == 0)                  expbit = 1'b0;
            else if (bi <= 8)             expbit = w[bi-1];
            else if (g == 1 && bi == 9)   expbit = ^w;
            else                          expbit = 1'b1;
            if (tx !== expbit) werr++;
            if (tx_done !== (k == nb * int'(Cps) - 1)) derr++;
            if (busy !== 1'b1) berr++;
            if (k % int'(Cps) == int'(Cps) / 2) begin
              if (bi >= 1 && bi <= 8) rx[bi-1] = tx;
              if (g == 1 && bi == 9) par = tx;
            end
          end
          if (!aborted) begin
            chk($sformatf("lane%0d_payload", g), rx, w);
            chk($sformatf("lane%0d_waveform_errs", g), werr, 0);
            chk($sformatf("lane%0d_tx_done_errs", g), derr, 0);
            chk($sformatf("lane%0d_busy_errs", g), berr, 0);
            last_rx  = rx;
            last_par = par;
            frames++;
            last_end = cyc;
          end
        end
        prev = tx;
      end
    end
  end

  task automatic push(input int g, input logic [7:0] w);
    mem[g][wptr[g] % 16]       = w;
    exp_mem[g][exp_wr[g] % 32] = w;
    exp_wr[g]++;
    wptr[g]++;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge r_clk);
      if (lane[0].exp_rd >= exp_wr[0] && lane[1].exp_rd >= exp_wr[1] &&
          !lane[0].busy && !lane[1].busy && lane[0].empty && lane[1].empty) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_idle_reached"}, int'(done), 1);
    repeat (2) @(negedge r_clk);
  endtask

  task automatic wait_tx_fall(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge r_clk);
      if (!lane[0].tx) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_tx_fall_seen"}, int'(seen), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int r0, f0, n0, errs;

    // Reset values.
    @(negedge r_clk);
    chk("rst_tx", lane[0].tx, 1);
    chk("rst_rd", lane[0].rd, 0);
    chk("rst_busy", lane[0].busy, 0);
    chk("rst_tx_done", lane[0].tx_done, 0);
    repeat (2) @(negedge r_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge r_clk);

    // Single word 0x68, no parity, with start latency.
    en = 1'b1;
    r0 = lane[0].rd_cnt; f0 = lane[0].frames;
    push(0, 8'h68);
    @(negedge r_clk);
    chk("lat_rd_high", lane[0].rd, 1);
    chk("lat_tx_idle_pop", lane[0].tx, 1);
    @(negedge r_clk);
    chk("rd_single_cycle", lane[0].rd, 0);
    chk("lat_tx_idle_load", lane[0].tx, 1);
    @(negedge r_clk);
    chk("lat_tx_start", lane[0].tx, 0);
    wait_idle("single");
    chk("single_rd_pulses", lane[0].rd_cnt - r0, 1);
    chk("single_frames", lane[0].frames - f0, 1);
    chk("single_rx", lane[0].last_rx, 8'h68);
    chk("single_busy_low", lane[0].busy, 0);

    // Even parity lane: 0x68 has three ones, 0x69 has four.
    push(1, 8'h68);
    wait_idle("par68");
    chk("par68_rx", lane[1].last_rx, 8'h68);
    chk("par68_bit", lane[1].last_par, 1);
    push(1, 8'h69);
    wait_idle("par69");
    chk("par69_rx", lane[1].last_rx, 8'h69);
    chk("par69_bit", lane[1].last_par, 0);

    // Preload with en low: no pop, then back-to-back drain.
    en = 1'b0;
    r0 = lane[0].rd_cnt; f0 = lane[0].frames; n0 = lane[0].gap_q.size();
    push(0, 8'd104);
    push(0, 8'd105);
    push(0, 8'd95);
    repeat (20) @(negedge r_clk);
    chk("en_low_no_pop", lane[0].rd_cnt - r0, 0);
    chk("en_low_tx_idle", lane[0].tx, 1);
    en = 1'b1;
    wait_idle("b2b");
    chk("b2b_rd_pulses", lane[0].rd_cnt - r0, 3);
    chk("b2b_frames", lane[0].frames - f0, 3);
    chk("b2b_last_rx", lane[0].last_rx, 8'd95);
    chk("b2b_gap_count", lane[0].gap_q.size() - n0, 3);
    if (lane[0].gap_q.size() >= n0 + 3) begin
      chk("b2b_gap_1", lane[0].gap_q[n0+1], 2);
      chk("b2b_gap_2", lane[0].gap_q[n0+2], 2);
    end
    chk("no_underflow_lane0", lane[0].underflow, 0);

    // Empty FIFO for 200 cycles.
    errs = 0;
    repeat (200) begin
      @(negedge r_clk);
      if (lane[0].rd !== 1'b0 || lane[0].tx !== 1'b1) errs++;
    end
    chk("empty_idle_errs", errs, 0);

    // en dropped during DATA: frame completes, no second pop.
    en = 1'b0;
    r0 = lane[0].rd_cnt; f0 = lane[0].frames;
    push(0, 8'hA5);
    push(0, 8'h3C);
    en = 1'b1;
    wait_tx_fall("endrop");
    repeat (10) @(negedge r_clk);
    en = 1'b0;
    repeat (60) @(negedge r_clk);
    chk("endrop_rd_pulses", lane[0].rd_cnt - r0, 1);
    chk("endrop_frames", lane[0].frames - f0, 1);
    chk("endrop_rx", lane[0].last_rx, 8'hA5);
    chk("endrop_busy_low", lane[0].busy, 0);
    en = 1'b1;
    wait_idle("endrop_resume");
    chk("endrop_resume_rx", lane[0].last_rx, 8'h3C);
    chk("endrop_resume_rd", lane[0].rd_cnt - r0, 2);

    // Reset during the third data bit, then a clean frame from the next word.
    push(0, 8'h5A);
    push(0, 8'hC3);
    wait_tx_fall("rstmid");
    repeat (12) @(negedge r_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_tx_high", lane[0].tx, 1);
    chk("rstmid_busy_low", lane[0].busy, 0);
    chk("rstmid_rd_low", lane[0].rd, 0);
    r0 = lane[0].rd_cnt; f0 = lane[0].frames;
    repeat (2) @(negedge r_clk);
    reset_n = 1'b1;
    wait_idle("rstmid");
    chk("rstmid_rd_pulses", lane[0].rd_cnt - r0, 1);
    chk("rstmid_frames", lane[0].frames - f0, 1);
    chk("rstmid_rx", lane[0].last_rx, 8'hC3);
    chk("no_underflow_final", lane[0].underflow + lane[1].underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
